// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase sequencer.
// Holds the phase ring, the per-phase sub-states, the interval select codes
// and the one-hot lamp encodings, plus helpers that map a phase to its lamps
// and interval select.
package traffic_pkg;

  // Phase ring in order of traversal.
  typedef enum logic [2:0] {
    MG1    = 3'd0,
    MG2    = 3'd1,
    MY     = 3'd2,
    WALK   = 3'd3,
    SG     = 3'd4,
    SG_EXT = 3'd5,
    SY     = 3'd6
  } phase_e;

  // Sub-states inside every phase: wait for the store, load, count down.
  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } sub_e;

  // Interval select codes understood by the parameter store.
  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;
  localparam logic [1:0] INT_DBL  = 2'b11;

  // {R,Y,G} one-hot lamp encodings.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } lights_t;

  localparam lights_t LIGHTS_RESET = '{main: GRN, side: RED};

  // Lamp pattern shown for a given phase.
  function automatic lights_t lights_of(input phase_e p);
    lights_t l;
    case (p)
      MG1, MG2:   l = '{main: GRN, side: RED};
      MY:         l = '{main: YEL, side: RED};
      WALK:       l = '{main: RED, side: RED};
      SG, SG_EXT: l = '{main: RED, side: GRN};
      SY:         l = '{main: RED, side: YEL};
      default:    l = LIGHTS_RESET;
    endcase
    return l;
  endfunction

  // Interval select for a phase; MG2 takes the extended time when the
  // sensor was active as MG1 expired.
  function automatic logic [1:0] interval_of(input phase_e p, input logic mg2_ext);
    logic [1:0] code;
    case (p)
      MG1:        code = INT_BASE;
      MG2:        code = mg2_ext ? INT_EXT : INT_BASE;
      MY, SY:     code = INT_YEL;
      WALK:       code = INT_EXT;
      SG:         code = INT_BASE;
      SG_EXT:     code = INT_EXT;
      default:    code = INT_BASE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_interval_countdown.sv
// interval_countdown: 4-bit loadable down counter for phase timing.
// A load of 0 is forced to 1 so every phase lasts at least one tick; the
// count never goes below 1, and expire pulses on a tick while the count is 1.
module interval_countdown (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       tick,
  output logic       expire
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: load has priority, otherwise step down on a tick, holding at 1.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = (load_value == 4'd0) ? 4'd1 : load_value;
    end else if (tick && (count_q > 4'd1)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!rst_n) count_q <= 4'd0;
    else        count_q <= count_d;
  end

  assign expire = tick && (count_q == 4'd1);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: drives the interval select into the time-parameter
// store, counts the returned value down in 1 Hz ticks and sequences the main,
// side and walk lamps through the phase ring.
// Optional feature macro: TRAFFIC_WALK_EN enables the WALK phase, the pending
// walk request and the walk lamp; without it MY always goes to SG.
module traffic_phase_sequencer
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       one_hz_en,
  input  logic       sensor_sync,
  input  logic       walk_request_sync,
  input  logic       reprog_sync,
  input  logic [3:0] value,
  output logic [1:0] interval,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk
);

  phase_e     phase_q, phase_d;
  sub_e       sub_q, sub_d;
  logic [1:0] interval_q, interval_d;
  lights_t    lights_q, lights_d;
  logic       enter;
  logic       expire;
  logic       walk_pending;

  // Phase timer: loads during LOAD, only counts ticks during RUN so ticks
  // arriving in WAIT or LOAD are dropped.
  interval_countdown u_countdown (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (sub_q == LOAD),
    .load_value (value),
    .tick       (one_hz_en && (sub_q == RUN)),
    .expire     (expire)
  );

  // State register: phase, sub-state and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= MG1;
      sub_q      <= WAIT;
      interval_q <= INT_BASE;
      lights_q   <= LIGHTS_RESET;
    end else begin
      phase_q    <= phase_d;
      sub_q      <= sub_d;
      interval_q <= interval_d;
      lights_q   <= lights_d;
    end
  end

  // Next state: reprogram wins over expiry; expiry advances the ring.
  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    enter   = 1'b0;
    if (reprog_sync) begin
      phase_d = MG1;
      sub_d   = WAIT;
      enter   = 1'b1;
    end else begin
      case (sub_q)
        WAIT: sub_d = LOAD;
        LOAD: sub_d = RUN;
        RUN: begin
          if (expire) begin
            enter = 1'b1;
            sub_d = WAIT;
            case (phase_q)
              MG1:     phase_d = MG2;
              MG2:     phase_d = MY;
              MY:      phase_d = walk_pending ? WALK : SG;
              WALK:    phase_d = SG;
              SG:      phase_d = sensor_sync ? SG_EXT : SY;
              SG_EXT:  phase_d = SY;
              SY:      phase_d = MG1;
              default: phase_d = MG1;
            endcase
          end
        end
        default: sub_d = WAIT;
      endcase
    end
  end

  // Outputs: interval and lamps change on the same edge as the phase.
  always_comb begin
    interval_d = interval_q;
    lights_d   = lights_q;
    if (enter) begin
      interval_d = interval_of(phase_d, sensor_sync);
      lights_d   = lights_of(phase_d);
    end
  end

  assign interval    = interval_q;
  assign main_lights = lights_q.main;
  assign side_lights = lights_q.side;

`ifdef TRAFFIC_WALK_EN
  logic walk_pending_q, walk_pending_d;
  logic walk_q, walk_d;

  // Walk bookkeeping: a request sets pending in any phase, entry to WALK
  // clears it, and a request on the entry cycle is kept for the next ring.
  always_comb begin
    walk_pending_d = walk_pending_q;
    walk_d         = walk_q;
    if (enter) begin
      walk_d = (phase_d == WALK);
      if (phase_d == WALK) walk_pending_d = 1'b0;
    end
    if (walk_request_sync) walk_pending_d = 1'b1;
  end

  // Walk registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_pending_q <= 1'b0;
      walk_q         <= 1'b0;
    end else begin
      walk_pending_q <= walk_pending_d;
      walk_q         <= walk_d;
    end
  end

  assign walk_pending = walk_pending_q;
  assign walk         = walk_q;
`else
  logic unused_walk_request;

  assign unused_walk_request = walk_request_sync;
  assign walk_pending        = 1'b0;
  assign walk                = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer. A phase-level reference model
// predicts the outputs after each clock edge; a monitor compares them.
// Honours TRAFFIC_WALK_EN the same way as the design.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       one_hz_en = 1'b0;
  logic       sensor_sync = 1'b0;
  logic       walk_request_sync = 1'b0;
  logic       reprog_sync = 1'b0;
  logic [3:0] value = 4'd0;
  logic [1:0] interval;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  traffic_phase_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .one_hz_en         (one_hz_en),
    .sensor_sync       (sensor_sync),
    .walk_request_sync (walk_request_sync),
    .reprog_sync       (reprog_sync),
    .value             (value),
    .interval          (interval),
    .main_lights       (main_lights),
    .side_lights       (side_lights),
    .walk              (walk)
  );

  // Parameter store: registered table lookup, one clock after interval.
  logic [3:0] tbl [4];
  always @(posedge clk) value <= tbl[interval];

  task automatic set_table(input int b, input int e, input int y);
    tbl[0] = 4'(b);
    tbl[1] = 4'(e);
    tbl[2] = 4'(y);
    tbl[3] = 4'(2 * b);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_MG1, M_MG2, M_MY, M_WALK, M_SG, M_SGX, M_SY} mph_t;
  mph_t       m_ph;
  int         m_age;   // cycles spent in the phase before this one
  int         m_got;   // ticks counted so far in the phase
  int         m_need;  // ticks the phase lasts
  bit         m_pend;
  logic [1:0] m_int;

  function automatic logic [6:0] lamps(input mph_t p);
    case (p)
      M_MG1, M_MG2: return {3'b001, 3'b100, 1'b0};
      M_MY:         return {3'b010, 3'b100, 1'b0};
      M_WALK:       return {3'b100, 3'b100, 1'b1};
      M_SG, M_SGX:  return {3'b100, 3'b001, 1'b0};
      default:      return {3'b100, 3'b010, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_ph = M_MG1; m_age = 0; m_got = 0; m_need = 1; m_pend = 0; m_int = 2'b00;
  endtask

  // Effect of one clock edge given the inputs held during the preceding cycle.
  // The first two cycles of a phase ignore ticks; the phase ends on the
  // tick that completes its loaded length (0 treated as 1).
  task automatic model_step(input bit tick, input bit sensor, input bit wreq, input bit reprog);
    bit   expire;
    mph_t nxt;
    if (m_age == 1) m_need = (tbl[m_int] == 4'd0) ? 1 : int'(tbl[m_int]);
    expire = (m_age >= 2) && tick && (m_got + 1 >= m_need);
    if ((m_age >= 2) && tick && !expire) m_got++;
    nxt = m_ph;
    case (m_ph)
      M_MG1:  nxt = M_MG2;
      M_MG2:  nxt = M_MY;
      M_MY:   nxt = m_pend ? M_WALK : M_SG;
      M_WALK: nxt = M_SG;
      M_SG:   nxt = sensor ? M_SGX : M_SY;
      M_SGX:  nxt = M_SY;
      default: nxt = M_MG1;
    endcase
`ifdef TRAFFIC_WALK_EN
    if (wreq) m_pend = 1;
    else if (!reprog && expire && nxt == M_WALK) m_pend = 0;
`endif
    if (reprog) begin
      m_ph = M_MG1; m_int = 2'b00; m_age = 0; m_got = 0;
    end else if (expire) begin
      m_ph = nxt; m_age = 0; m_got = 0;
      case (nxt)
        M_MG2:         m_int = sensor ? 2'b01 : 2'b00;
        M_MY, M_SY:    m_int = 2'b10;
        M_WALK, M_SGX: m_int = 2'b01;
        default:       m_int = 2'b00;
      endcase
    end else begin
      m_age++;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [2:0] obs_main, obs_side;

  // Monitor: after each edge, compare the DUT outputs with the oldest prediction.
  initial begin
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{int,main,side,walk}", 16'({interval, main_lights, side_lights, walk}), 16'(e));
      end
    end
  end

  task automatic cycle(input bit tick, input bit sensor, input bit wreq, input bit reprog);
    @(negedge clk);
    obs_main = main_lights;
    obs_side = side_lights;
    one_hz_en = tick; sensor_sync = sensor; walk_request_sync = wreq; reprog_sync = reprog;
    model_step(tick, sensor, wreq, reprog);
    exp_q.push_back({m_int, lamps(m_ph)});
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] s1_main [40];
  logic [2:0] s1_side [40];

  function automatic int run_len(input logic [2:0] a [40], input int start);
    int n = 0;
    while (start + n < 40 && a[start + n] == a[start]) n++;
    return n;
  endfunction

  initial begin
    int ml0, ml1, sl0, sl1, k;
    bit hit;
    set_table(6, 3, 2);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset interval", 16'(interval), 16'h0);
    check("reset main", 16'(main_lights), 16'h1);
    check("reset side", 16'(side_lights), 16'h4);
    check("reset walk", 16'(walk), 16'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: tick every cycle, sensor 0, no walk; record lamp run lengths.
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, 0);
      s1_main[i] = obs_main;
      s1_side[i] = obs_side;
    end
    ml0 = run_len(s1_main, 0);
    ml1 = run_len(s1_main, ml0);
    sl0 = run_len(s1_side, 0);
    sl1 = run_len(s1_side, sl0);
    check("main green dwell MG1+MG2", 16'(ml0), 16'd16);
    check("main yellow dwell MY", 16'(ml1), 16'd4);
    check("main red dwell SG+SY", 16'(run_len(s1_main, ml0 + ml1)), 16'd12);
    check("side red dwell", 16'(sl0), 16'd20);
    check("side green dwell SG", 16'(sl1), 16'd8);
    check("side yellow dwell SY", 16'(run_len(s1_side, sl0 + sl1)), 16'd4);

    // 2: sensor held high, restarted from MG1.
    cycle(1, 1, 0, 1);
    repeat (50) cycle(1, 1, 0, 0);

    // 3: walk pulse during MG1.
    cycle(1, 0, 0, 1);
    cycle(1, 0, 1, 0);
    repeat (50) cycle(1, 0, 0, 0);

    // 4: t_base reprogrammed to 0, then restored.
    set_table(0, 3, 2);
    cycle(1, 0, 0, 1);
    repeat (40) cycle(1, 0, 0, 0);
    set_table(6, 3, 2);
    cycle(1, 0, 0, 1);

    // 5: reprogram pulse in the middle of SY.
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_ph == M_SY && m_age >= 2) hit = 1;
      else cycle(1, $urandom_range(0, 1), 0, 0);
    end
    check("reach SY within budget", 16'(hit), 16'd1);
    cycle(1, 0, 0, 1);
    repeat (10) cycle(1, 0, 0, 0);

    // 6: ticks only on WAIT/LOAD of MY, then every 4th cycle.
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_ph == M_MY && m_age == 0) hit = 1;
      else cycle(1, 0, 0, 0);
    end
    check("reach MY within budget", 16'(hit), 16'd1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) cycle((i % 4) == 3, 0, 0, 0);

    // 7: randomized mix of ticks, sensor, walk requests and reprograms.
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 99);
      if (k < 2) begin
        if ($urandom_range(0, 3) == 0)
          set_table($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 19) == 0, 1);
      end else begin
        cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 19) == 0, 0);
      end
    end

    // Asynchronous reset mid-phase.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async reset interval", 16'(interval), 16'h0);
    check("async reset main", 16'(main_lights), 16'h1);
    check("async reset side", 16'(side_lights), 16'h4);
    check("async reset walk", 16'(walk), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
